// File: rtl/pipe_controller.sv
// Pipelined main/ALU decoder: decodes op/funct in ID, then carries the control word
// through ID/EX, EX/MEM and MEM/WB. Optional bne decode is enabled by PIPE_CTRL_BNE_EN.
module pipe_controller #(
    parameter int unsigned ALU_CTRL_W   = 3,
    parameter int unsigned BRANCH_IN_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  eq_d,
    input  logic                  zero_e,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic                  jmp_d,
    output logic                  illegal_d,
    output logic                  pc_src,
    output logic                  branch_flush,
    output logic                  alu_src_e,
    output logic                  reg_dst_e,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic                  mem_write_m,
    output logic                  reg_write_e,
    output logic                  reg_write_m,
    output logic                  reg_write_w,
    output logic                  mem_to_reg_e,
    output logic                  mem_to_reg_m,
    output logic                  mem_to_reg_w
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef PIPE_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control word held in the ID/EX register
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  branch;
`ifdef PIPE_CTRL_BNE_EN
        logic                  branch_ne;
`endif
        logic                  alu_src;
        logic                  reg_dst;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } ctrl_t;

    ctrl_t      ctrl_id;
    ctrl_t      idex_d;
    ctrl_t      idex_q;
    logic       funct_ok;
    logic [2:0] funct_alu;

    logic exmem_reg_write_q;
    logic exmem_mem_to_reg_q;
    logic exmem_mem_write_q;
    logic memwb_reg_write_q;
    logic memwb_mem_to_reg_q;

    // R-type funct to ALU code
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Main decoder; illegal encodings leave the control word as a nop
    always_comb begin
        ctrl_id   = '0;
        jmp_d     = 1'b0;
        illegal_d = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct_ok) begin
                    ctrl_id.reg_write = 1'b1;
                    ctrl_id.reg_dst   = 1'b1;
                    ctrl_id.alu_ctrl  = ALU_CTRL_W'(funct_alu);
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_id.reg_write  = 1'b1;
                ctrl_id.alu_src    = 1'b1;
                ctrl_id.mem_to_reg = 1'b1;
                ctrl_id.alu_ctrl   = ALU_CTRL_W'(ALU_ADD);
            end
            OP_SW: begin
                ctrl_id.mem_write = 1'b1;
                ctrl_id.alu_src   = 1'b1;
                ctrl_id.alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
            end
            OP_BEQ: begin
                ctrl_id.branch   = 1'b1;
                ctrl_id.alu_ctrl = ALU_CTRL_W'(ALU_SUB);
            end
`ifdef PIPE_CTRL_BNE_EN
            OP_BNE: begin
                ctrl_id.branch    = 1'b1;
                ctrl_id.branch_ne = 1'b1;
                ctrl_id.alu_ctrl  = ALU_CTRL_W'(ALU_SUB);
            end
`endif
            OP_ADDI: begin
                ctrl_id.reg_write = 1'b1;
                ctrl_id.alu_src   = 1'b1;
                ctrl_id.alu_ctrl  = ALU_CTRL_W'(ALU_ADD);
            end
            OP_J:    jmp_d     = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // ID/EX next value: flush beats stall beats load
    always_comb begin
        idex_d = idex_q;
        if (flush_e) begin
            idex_d = '0;
        end else if (!stall_e) begin
            idex_d = ctrl_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= 1'b0;
            exmem_mem_write_q  <= 1'b0;
            memwb_reg_write_q  <= 1'b0;
            memwb_mem_to_reg_q <= 1'b0;
        end else begin
            exmem_reg_write_q  <= idex_q.reg_write;
            exmem_mem_to_reg_q <= idex_q.mem_to_reg;
            exmem_mem_write_q  <= idex_q.mem_write;
            memwb_reg_write_q  <= exmem_reg_write_q;
            memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
        end
    end

    // Branch resolution point is chosen at elaboration
    generate
        if (BRANCH_IN_ID != 0) begin : g_branch_id
            logic taken_id;
`ifdef PIPE_CTRL_BNE_EN
            assign taken_id = ctrl_id.branch & (eq_d ^ ctrl_id.branch_ne);
`else
            assign taken_id = ctrl_id.branch & eq_d;
`endif
            assign pc_src = rst_n & taken_id;
        end else begin : g_branch_ex
`ifdef PIPE_CTRL_BNE_EN
            assign pc_src = idex_q.branch & (zero_e ^ idex_q.branch_ne);
`else
            assign pc_src = idex_q.branch & zero_e;
`endif
        end
    endgenerate

    assign branch_flush = pc_src;

    // Only one of the two flag inputs is consumed per configuration
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{eq_d, zero_e, idex_q.branch};
`ifdef PIPE_CTRL_BNE_EN
    logic unused_branch_ne;
    assign unused_branch_ne = idex_q.branch_ne;
`endif

    assign alu_src_e    = idex_q.alu_src;
    assign reg_dst_e    = idex_q.reg_dst;
    assign alu_ctrl_e   = idex_q.alu_ctrl;
    assign reg_write_e  = idex_q.reg_write;
    assign mem_to_reg_e = idex_q.mem_to_reg;
    assign mem_write_m  = exmem_mem_write_q;
    assign reg_write_m  = exmem_reg_write_q;
    assign mem_to_reg_m = exmem_mem_to_reg_q;
    assign reg_write_w  = memwb_reg_write_q;
    assign mem_to_reg_w = memwb_mem_to_reg_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: one instance per branch-resolution mode,
// both checked every cycle against an instruction-history reference model.
module tb_pipe_controller;

    localparam int unsigned AW = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    typedef struct packed {
        logic       rw;
        logic       mtr;
        logic       mw;
        logic       br;
        logic       bne;
        logic       asrc;
        logic       rdst;
        logic [2:0] alu;
        logic       jmp;
        logic       ill;
    } mctrl_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic [5:0] op      = '0;
    logic [5:0] funct   = '0;
    logic       eq_d    = 1'b0;
    logic       zero_e  = 1'b0;
    logic       stall_e = 1'b0;
    logic       flush_e = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic          ex_jmp_d, ex_illegal_d, ex_pc_src, ex_branch_flush, ex_alu_src_e, ex_reg_dst_e;
    logic          ex_mem_write_m, ex_reg_write_e, ex_reg_write_m, ex_reg_write_w;
    logic          ex_mem_to_reg_e, ex_mem_to_reg_m, ex_mem_to_reg_w;
    logic [AW-1:0] ex_alu_ctrl_e;
    logic          id_jmp_d, id_illegal_d, id_pc_src, id_branch_flush, id_alu_src_e, id_reg_dst_e;
    logic          id_mem_write_m, id_reg_write_e, id_reg_write_m, id_reg_write_w;
    logic          id_mem_to_reg_e, id_mem_to_reg_m, id_mem_to_reg_w;
    logic [AW-1:0] id_alu_ctrl_e;

    always #5 clk = ~clk;

    pipe_controller #(.ALU_CTRL_W(AW), .BRANCH_IN_ID(0)) u_ex (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .eq_d(eq_d), .zero_e(zero_e),
        .stall_e(stall_e), .flush_e(flush_e), .jmp_d(ex_jmp_d), .illegal_d(ex_illegal_d),
        .pc_src(ex_pc_src), .branch_flush(ex_branch_flush), .alu_src_e(ex_alu_src_e),
        .reg_dst_e(ex_reg_dst_e), .alu_ctrl_e(ex_alu_ctrl_e), .mem_write_m(ex_mem_write_m),
        .reg_write_e(ex_reg_write_e), .reg_write_m(ex_reg_write_m), .reg_write_w(ex_reg_write_w),
        .mem_to_reg_e(ex_mem_to_reg_e), .mem_to_reg_m(ex_mem_to_reg_m), .mem_to_reg_w(ex_mem_to_reg_w)
    );

    pipe_controller #(.ALU_CTRL_W(AW), .BRANCH_IN_ID(1)) u_id (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .eq_d(eq_d), .zero_e(zero_e),
        .stall_e(stall_e), .flush_e(flush_e), .jmp_d(id_jmp_d), .illegal_d(id_illegal_d),
        .pc_src(id_pc_src), .branch_flush(id_branch_flush), .alu_src_e(id_alu_src_e),
        .reg_dst_e(id_reg_dst_e), .alu_ctrl_e(id_alu_ctrl_e), .mem_write_m(id_mem_write_m),
        .reg_write_e(id_reg_write_e), .reg_write_m(id_reg_write_m), .reg_write_w(id_reg_write_w),
        .mem_to_reg_e(id_mem_to_reg_e), .mem_to_reg_m(id_mem_to_reg_m), .mem_to_reg_w(id_mem_to_reg_w)
    );

    // Instruction-table view of what each opcode asks for
    function automatic mctrl_t ref_decode(input logic [5:0] o, input logic [5:0] f);
        mctrl_t c;
        c = '0;
        case (o)
            OP_R: begin
                c.rw   = 1'b1;
                c.rdst = 1'b1;
                case (f)
                    F_ADD:   c.alu = 3'b010;
                    F_SUB:   c.alu = 3'b110;
                    F_AND:   c.alu = 3'b000;
                    F_OR:    c.alu = 3'b001;
                    F_SLT:   c.alu = 3'b111;
                    default: begin c = '0; c.ill = 1'b1; end
                endcase
            end
            OP_LW:   begin c.rw = 1'b1; c.asrc = 1'b1; c.mtr = 1'b1; c.alu = 3'b010; end
            OP_SW:   begin c.mw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            OP_BEQ:  begin c.br = 1'b1; c.alu = 3'b110; end
`ifdef PIPE_CTRL_BNE_EN
            OP_BNE:  begin c.br = 1'b1; c.bne = 1'b1; c.alu = 3'b110; end
`endif
            OP_ADDI: begin c.rw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            OP_J:    c.jmp = 1'b1;
            default: c.ill = 1'b1;
        endcase
        return c;
    endfunction

    // ex_hist[k]: control of the slot that occupied EX k cycles ago (so [1]=M, [2]=W)
    mctrl_t ex_hist [3] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_hist <= '{default: '0};
        end else begin
            ex_hist[2] <= ex_hist[1];
            ex_hist[1] <= ex_hist[0];
            if (flush_e)       ex_hist[0] <= '0;
            else if (!stall_e) ex_hist[0] <= ref_decode(op, funct);
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input logic id_mode,
                              input logic jmp, input logic ill, input logic pc, input logic bf,
                              input logic asrc, input logic rdst, input logic [2:0] alu,
                              input logic mw_m, input logic rw_e, input logic rw_m, input logic rw_w,
                              input logic mtr_e, input logic mtr_m, input logic mtr_w);
        mctrl_t d, e, m, w;
        logic   exp_pc;
        d = ref_decode(op, funct);
        e = ex_hist[0];
        m = ex_hist[1];
        w = ex_hist[2];
        exp_pc = id_mode ? (rst_n & d.br & (eq_d ^ d.bne)) : (e.br & (zero_e ^ e.bne));
        chk1({tag, ".jmp_d"}, jmp, d.jmp);
        chk1({tag, ".illegal_d"}, ill, d.ill);
        chk1({tag, ".pc_src"}, pc, exp_pc);
        chk1({tag, ".branch_flush"}, bf, exp_pc);
        chk1({tag, ".alu_src_e"}, asrc, e.asrc);
        chk1({tag, ".reg_dst_e"}, rdst, e.rdst);
        chk3({tag, ".alu_ctrl_e"}, alu, e.alu);
        chk1({tag, ".reg_write_e"}, rw_e, e.rw);
        chk1({tag, ".mem_to_reg_e"}, mtr_e, e.mtr);
        chk1({tag, ".mem_write_m"}, mw_m, m.mw);
        chk1({tag, ".reg_write_m"}, rw_m, m.rw);
        chk1({tag, ".mem_to_reg_m"}, mtr_m, m.mtr);
        chk1({tag, ".reg_write_w"}, rw_w, w.rw);
        chk1({tag, ".mem_to_reg_w"}, mtr_w, w.mtr);
    endtask

    // Every-cycle comparison on the falling edge, away from register updates
    initial begin : compare
        forever begin
            @(negedge clk);
            check_inst("ex", 1'b0, ex_jmp_d, ex_illegal_d, ex_pc_src, ex_branch_flush, ex_alu_src_e,
                       ex_reg_dst_e, ex_alu_ctrl_e, ex_mem_write_m, ex_reg_write_e, ex_reg_write_m,
                       ex_reg_write_w, ex_mem_to_reg_e, ex_mem_to_reg_m, ex_mem_to_reg_w);
            check_inst("id", 1'b1, id_jmp_d, id_illegal_d, id_pc_src, id_branch_flush, id_alu_src_e,
                       id_reg_dst_e, id_alu_ctrl_e, id_mem_write_m, id_reg_write_e, id_reg_write_m,
                       id_reg_write_w, id_mem_to_reg_e, id_mem_to_reg_m, id_mem_to_reg_w);
        end
    end

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic st,
                         input logic fl, input logic eq, input logic z);
        op      = o;
        funct   = f;
        stall_e = st;
        flush_e = fl;
        eq_d    = eq;
        zero_e  = z;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        logic [5:0] o;
        logic [5:0] f;

        // Reset: registered outputs zero, decode follows op
        #1 rst_n = 1'b0;
        drive(OP_J, F_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk1("rst jmp_d follows op", ex_jmp_d, 1'b1);
        chk1("rst reg_write_e", ex_reg_write_e, 1'b0);
        chk1("rst mem_to_reg_w", ex_mem_to_reg_w, 1'b0);
        chk1("rst pc_src ex", ex_pc_src, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        drive(OP_LW, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw reaches EX one cycle after decode
        next_cycle();
        chk1("lw reg_write_e", ex_reg_write_e, 1'b1);
        chk1("lw alu_src_e", ex_alu_src_e, 1'b1);
        chk1("lw mem_to_reg_e", ex_mem_to_reg_e, 1'b1);
        chk3("lw alu_ctrl_e", ex_alu_ctrl_e, 3'b010);
        drive(OP_R, F_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk3("sub alu_ctrl_e", ex_alu_ctrl_e, 3'b110);
        chk1("sub reg_dst_e", ex_reg_dst_e, 1'b1);
        chk1("lw mem_to_reg_m", ex_mem_to_reg_m, 1'b1);
        drive(OP_SW, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk1("lw mem_to_reg_w", ex_mem_to_reg_w, 1'b1);
        chk1("sw reg_write_e", ex_reg_write_e, 1'b0);

        // addi with flush and stall together becomes a bubble
        drive(OP_ADDI, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        chk1("flush reg_write_e", ex_reg_write_e, 1'b0);
        chk1("flush alu_src_e", ex_alu_src_e, 1'b0);
        chk3("flush alu_ctrl_e", ex_alu_ctrl_e, 3'b000);
        chk1("sw mem_write_m", ex_mem_write_m, 1'b1);
        chk1("sw reg_write_m", ex_reg_write_m, 1'b0);
        drive(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk1("bubble reg_write_m", ex_reg_write_m, 1'b0);
        drive(OP_R, F_OR, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk1("bubble reg_write_w", ex_reg_write_w, 1'b0);
        chk1("add reg_write_m", ex_reg_write_m, 1'b1);
        chk3("or alu_ctrl_e", ex_alu_ctrl_e, 3'b001);

        // beq: ID resolution uses eq_d at decode, EX resolution uses zero_e a cycle later
        drive(OP_BEQ, F_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk1("beq id pc_src", id_pc_src, 1'b1);
        chk1("beq id branch_flush", id_branch_flush, 1'b1);
        chk1("beq ex pc_src early", ex_pc_src, 1'b0);
        next_cycle();
        zero_e = 1'b1;
        #1;
        chk1("beq ex pc_src taken", ex_pc_src, 1'b1);
        chk1("beq ex branch_flush", ex_branch_flush, 1'b1);
        drive(OP_R, F_AND, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        #1;
        chk1("beq ex pc_src one cycle", ex_pc_src, 1'b0);
        drive(OP_BEQ, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("beq id not taken", id_pc_src, 1'b0);
        next_cycle();
        #1;
        chk1("beq ex not taken", ex_pc_src, 1'b0);

        // bne opcode
        drive(OP_BNE, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef PIPE_CTRL_BNE_EN
        chk1("bne illegal_d", ex_illegal_d, 1'b0);
        chk1("bne id pc_src", id_pc_src, 1'b1);
        next_cycle();
        #1;
        chk1("bne ex pc_src", ex_pc_src, 1'b1);
`else
        chk1("bne illegal_d", ex_illegal_d, 1'b1);
        chk1("bne id pc_src", id_pc_src, 1'b0);
        next_cycle();
        chk3("bne nop alu_ctrl_e", ex_alu_ctrl_e, 3'b000);
`endif

        // Unmapped funct
        drive(OP_R, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("bad funct illegal_d", ex_illegal_d, 1'b1);
        next_cycle();
        chk1("bad funct reg_write_e", ex_reg_write_e, 1'b0);
        chk1("bad funct reg_dst_e", ex_reg_dst_e, 1'b0);

        // Reset mid-stream: lw in M, addi in EX
        drive(OP_LW, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(OP_ADDI, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk1("pre-rst addi reg_write_e", ex_reg_write_e, 1'b1);
        chk1("pre-rst lw mem_to_reg_m", ex_mem_to_reg_m, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("async rst reg_write_e", ex_reg_write_e, 1'b0);
        chk1("async rst mem_to_reg_m", ex_mem_to_reg_m, 1'b0);
        chk1("async rst reg_write_m", ex_reg_write_m, 1'b0);
        chk1("async rst alu_src_e", id_alu_src_e, 1'b0);
        drive(OP_SW, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        chk1("post-rst sw alu_src_e", ex_alu_src_e, 1'b1);
        chk3("post-rst sw alu_ctrl_e", ex_alu_ctrl_e, 3'b010);
        next_cycle();
        chk1("post-rst sw mem_write_m", ex_mem_write_m, 1'b1);

        // Randomized traffic with occasional stall, flush and reset
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 8))
                0, 1:    o = OP_R;
                2:       o = OP_LW;
                3:       o = OP_SW;
                4:       o = OP_BEQ;
                5:       o = OP_ADDI;
                6:       o = OP_J;
                7:       o = OP_BNE;
                default: o = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0:       f = F_ADD;
                1:       f = F_SUB;
                2:       f = F_AND;
                3:       f = F_OR;
                4:       f = F_SLT;
                default: f = 6'($urandom);
            endcase
            rst_n = ($urandom_range(0, 59) != 0);
            drive(o, f, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                  1'($urandom), 1'($urandom));
            next_cycle();
        end

        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
